hc_csr_bank: RTL and testbench
==============================

// Module: hc_csr_bank
// PURPOSE
//  Parametrised MMIO CSR bank and run-control FSM for HardCloud AFUs on CCI-P.
//  Serves DFH/AFU-ID reads, decodes host writes to DSM/SRC/DST/NUM_LINES/CTL, and
//  exposes N read-only user status words. Sits between registered sRx.c0/sTx.c2 and AFU datapath.
// PARAMETERS
//  AFU_ID         128'h0   AFU UUID returned at dword addr 2 (low) / 4 (high)
//  DFH_NEXT       24'h0    DFH next-offset field [39:16]
//  DFH_EOL        1        DFH end-of-list bit [40]
//  NUM_USER_CSRS  4        read-only 64b status words, 1..16
//  USER_BASE      16'h180  byte offset of status word 0; word i at USER_BASE+8*i
// PORTS
//  clk            in   1     CCI-P clock (pClk)
//  reset          in   1     asynchronous, active-high
//  mmio_rd_valid  in   1     MMIO read request (sRx.c0.mmioRdValid)
//  mmio_wr_valid  in   1     MMIO write request (sRx.c0.mmioWrValid)
//  mmio_addr      in   16    dword address (byte offset >> 2)
//  mmio_len       in   2     0 = 32b access, 1 = 64b access
//  mmio_tid       in   9     transaction ID
//  mmio_wr_data   in   64    write data
//  rd_rsp_valid   out  1     read response valid (sTx.c2.mmioRdValid)
//  rd_rsp_tid     out  9     echoed tid
//  rd_rsp_data    out  64    read data
//  dsm_base       out  64    CSR 0x110; src_addr out 64 (0x120); dst_addr out 64 (0x128)
//  num_lines      out  32    CSR 0x130
//  afu_rst        out  1     high while FSM in IN_RESET
//  start_pulse    out  1     1-cycle pulse on IDLE->RUN
//  stop_pulse     out  1     1-cycle pulse on host stop
//  running        out  1     FSM in RUN
//  done_i         in   1     datapath completion pulse
//  status_i       in   64*NUM_USER_CSRS  user status, word i at [64i+:64]
// BEHAVIOUR
//  Reset (async): all outputs 0 except afu_rst=1; registers 0; FSM=IN_RESET; cycle_cnt=0.
//  Reads: every read answered exactly once, latency 1 (rsp in cycle after request), tid echoed.
//   Map (byte): 0x00 DFH {[63:60]=4'h1,[40]=DFH_EOL,[39:16]=DFH_NEXT}; 0x08/0x10 AFU_ID lo/hi;
//   0x18/0x20 zero; 0x110..0x138 readback; 0x140 cycle_cnt; 0x148 {62'b0,state}; user words;
//   unmapped -> 0. 32b read of odd dword returns upper half in data[31:0].
//  Writes: 64b write updates full register; 32b write updates half selected by mmio_addr[0].
//   num_lines/CTL use [31:0] only. Writes to RO/unmapped addresses ignored.
//   src/dst/num_lines/dsm writes ignored while running=1.
//  Read and write same cycle: write applied; read returns pre-write value.
//  CTL FSM (hc_ctl_fsm), states IN_RESET/IDLE/RUN/DONE, codes 0/1/2/3:
//   any state, CTL=0 -> IN_RESET; IN_RESET|DONE, CTL=1 -> IDLE;
//   IDLE, CTL=3 -> RUN + start_pulse; RUN, CTL=7 -> DONE + stop_pulse;
//   RUN, done_i -> DONE; done_i and CTL=7 same cycle -> DONE, no stop_pulse.
//   Other CTL codes / illegal-state codes ignored. done_i outside RUN ignored.
//  cycle_cnt: 64b, cleared on IDLE->RUN, +1 each RUN cycle, frozen elsewhere, wraps at 2^64.
//  Pulses are registered; asserted in the cycle after the CTL write/done_i.
// STRUCTURE
//  hc_csr_pkg: CSR byte offsets, CTL codes, t_ctl_state enum, DFH field layout.
//  Sub-module hc_ctl_fsm: FSM, pulses, cycle_cnt; top holds decode, regs, read mux.
// TESTING
//  Reset then rd 0x00,0x08,0x10 tid 5,6,7 -> DFH 0x1000_0100_0000_0000, AFU_ID lo/hi, tids echoed.
//  64b wr 0x120=0xDEAD_BEEF_0000_1000; 32b wr dword 0x4A=0x1234 -> rd 0x128 upper=0, low=0x1234.
//  CTL 1,3 -> start_pulse 1 cycle, running=1; 10 cycles, CTL 7 -> stop_pulse, rd 0x148=3, cnt~=10.
//  RUN: wr num_lines=8 ignored; done_i with CTL 7 same cycle -> DONE, stop_pulse stays 0.
//  Reset asserted mid-RUN -> running=0, afu_rst=1 same cycle, all CSRs read 0 after release.
//  NUM_USER_CSRS=4, status_i word3=0xABCD -> rd 0x198 returns 0xABCD; rd 0x1A0 returns 0.

Source files
------------

// File: rtl/hc_csr_pkg.sv
// Shared constants and types for the HardCloud CSR bank:
// CSR byte offsets, CTL command codes, run-control states and DFH layout.
package hc_csr_pkg;

    localparam logic [15:0] CSR_DFH    = 16'h000;
    localparam logic [15:0] CSR_AFU_LO = 16'h008;
    localparam logic [15:0] CSR_AFU_HI = 16'h010;
    localparam logic [15:0] CSR_DSM    = 16'h110;
    localparam logic [15:0] CSR_SRC    = 16'h120;
    localparam logic [15:0] CSR_DST    = 16'h128;
    localparam logic [15:0] CSR_NUM    = 16'h130;
    localparam logic [15:0] CSR_CTL    = 16'h138;
    localparam logic [15:0] CSR_CNT    = 16'h140;
    localparam logic [15:0] CSR_STATE  = 16'h148;

    localparam logic [31:0] CTL_RESET = 32'd0;
    localparam logic [31:0] CTL_IDLE  = 32'd1;
    localparam logic [31:0] CTL_START = 32'd3;
    localparam logic [31:0] CTL_STOP  = 32'd7;

    localparam logic [3:0] DFH_TYPE_AFU = 4'h1;

    typedef enum logic [1:0] {
        ST_IN_RESET = 2'd0,
        ST_IDLE     = 2'd1,
        ST_RUN      = 2'd2,
        ST_DONE     = 2'd3
    } t_ctl_state;

    // 64-bit word index of a byte offset
    function automatic logic [14:0] csr_w(input logic [15:0] off);
        return 15'(off >> 3);
    endfunction

    function automatic logic [63:0] dfh_word(input logic [23:0] nxt, input logic eol);
        return {DFH_TYPE_AFU, 19'b0, eol, nxt, 16'b0};
    endfunction

endpackage

// File: rtl/hc_ctl_fsm.sv
// Run-control FSM for the AFU: decodes CTL commands and datapath
// completion into state, start/stop pulses and the RUN cycle counter.
module hc_ctl_fsm
    import hc_csr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ctl_we,
    input  logic [31:0] ctl_val,
    input  logic        done_i,
    output t_ctl_state  state,
    output logic        start_pulse,
    output logic        stop_pulse,
    output logic [63:0] cycle_cnt
);

    t_ctl_state  state_q, state_d;
    logic        start_q, start_d;
    logic        stop_q, stop_d;
    logic [63:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        stop_d  = 1'b0;
        cnt_d   = cnt_q;
        if (state_q == ST_RUN) cnt_d = cnt_q + 64'd1;
        if (ctl_we && ctl_val == CTL_RESET) begin
            state_d = ST_IN_RESET;
        end else begin
            unique case (state_q)
                ST_IN_RESET, ST_DONE: begin
                    if (ctl_we && ctl_val == CTL_IDLE) state_d = ST_IDLE;
                end
                ST_IDLE: begin
                    if (ctl_we && ctl_val == CTL_START) begin
                        state_d = ST_RUN;
                        start_d = 1'b1;
                        cnt_d   = '0;
                    end
                end
                ST_RUN: begin
                    // completion wins over a simultaneous host stop
                    if (done_i) begin
                        state_d = ST_DONE;
                    end else if (ctl_we && ctl_val == CTL_STOP) begin
                        state_d = ST_DONE;
                        stop_d  = 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IN_RESET;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state       = state_q;
    assign start_pulse = start_q;
    assign stop_pulse  = stop_q;
    assign cycle_cnt   = cnt_q;

endmodule

// File: rtl/hc_csr_bank.sv
// MMIO CSR bank for HardCloud AFUs: DFH/AFU-ID reads, host-written
// job registers, run-control, and read-only user status words.
module hc_csr_bank
    import hc_csr_pkg::*;
#(
    parameter logic [127:0] AFU_ID        = '0,
    parameter logic [23:0]  DFH_NEXT      = '0,
    parameter logic         DFH_EOL       = 1'b1,
    parameter int           NUM_USER_CSRS = 4,
    parameter logic [15:0]  USER_BASE     = 16'h180
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mmio_rd_valid,
    input  logic                       mmio_wr_valid,
    input  logic [15:0]                mmio_addr,
    input  logic [1:0]                 mmio_len,
    input  logic [8:0]                 mmio_tid,
    input  logic [63:0]                mmio_wr_data,
    output logic                       rd_rsp_valid,
    output logic [8:0]                 rd_rsp_tid,
    output logic [63:0]                rd_rsp_data,
    output logic [63:0]                dsm_base,
    output logic [63:0]                src_addr,
    output logic [63:0]                dst_addr,
    output logic [31:0]                num_lines,
    output logic                       afu_rst,
    output logic                       start_pulse,
    output logic                       stop_pulse,
    output logic                       running,
    input  logic                       done_i,
    input  logic [64*NUM_USER_CSRS-1:0] status_i
);

    logic [63:0] dsm_q, dsm_d, src_q, src_d, dst_q, dst_d;
    logic [31:0] num_q, num_d, ctl_q, ctl_d;
    logic        rd_valid_q, rd_valid_d;
    logic [8:0]  rd_tid_q, rd_tid_d;
    logic [63:0] rd_data_q, rd_data_d;
    logic        ctl_we;
    t_ctl_state  state;
    logic [63:0] cycle_cnt;
    logic [63:0] rd_word;
    logic [63:0] user_w [16];
    logic [14:0] widx, user_rel;
    logic        len64, lo_ok, user_hit;

    assign widx     = mmio_addr[15:1];
    assign len64    = (mmio_len == 2'd1);
    assign lo_ok    = len64 || !mmio_addr[0];
    assign user_rel = widx - csr_w(USER_BASE);
    assign user_hit = (widx >= csr_w(USER_BASE)) && (user_rel[14:4] == '0);

    for (genvar g = 0; g < 16; g++) begin : g_user
        if (g < NUM_USER_CSRS) begin : g_on
            assign user_w[g] = status_i[64*g +: 64];
        end else begin : g_off
            assign user_w[g] = '0;
        end
    end

    // 32-bit writes replace only the half picked by the dword address
    function automatic logic [63:0] merge(input logic [63:0] old,
                                          input logic [63:0] wd,
                                          input logic full,
                                          input logic hi);
        if (full) return wd;
        if (hi) return {wd[31:0], old[31:0]};
        return {old[63:32], wd[31:0]};
    endfunction

    always_comb begin
        dsm_d  = dsm_q;
        src_d  = src_q;
        dst_d  = dst_q;
        num_d  = num_q;
        ctl_d  = ctl_q;
        ctl_we = 1'b0;
        if (mmio_wr_valid) begin
            unique case (1'b1)
                widx == csr_w(CSR_DSM):
                    if (!running) dsm_d = merge(dsm_q, mmio_wr_data, len64, mmio_addr[0]);
                widx == csr_w(CSR_SRC):
                    if (!running) src_d = merge(src_q, mmio_wr_data, len64, mmio_addr[0]);
                widx == csr_w(CSR_DST):
                    if (!running) dst_d = merge(dst_q, mmio_wr_data, len64, mmio_addr[0]);
                widx == csr_w(CSR_NUM):
                    if (!running && lo_ok) num_d = mmio_wr_data[31:0];
                widx == csr_w(CSR_CTL):
                    if (lo_ok) begin
                        ctl_d  = mmio_wr_data[31:0];
                        ctl_we = 1'b1;
                    end
                default: ctl_we = 1'b0;
            endcase
        end
    end

    always_comb begin
        rd_word = '0;
        unique case (1'b1)
            widx == csr_w(CSR_DFH):    rd_word = dfh_word(DFH_NEXT, DFH_EOL);
            widx == csr_w(CSR_AFU_LO): rd_word = AFU_ID[63:0];
            widx == csr_w(CSR_AFU_HI): rd_word = AFU_ID[127:64];
            widx == csr_w(CSR_DSM):    rd_word = dsm_q;
            widx == csr_w(CSR_SRC):    rd_word = src_q;
            widx == csr_w(CSR_DST):    rd_word = dst_q;
            widx == csr_w(CSR_NUM):    rd_word = {32'b0, num_q};
            widx == csr_w(CSR_CTL):    rd_word = {32'b0, ctl_q};
            widx == csr_w(CSR_CNT):    rd_word = cycle_cnt;
            widx == csr_w(CSR_STATE):  rd_word = {62'b0, state};
            user_hit:                  rd_word = user_w[user_rel[3:0]];
            default:                   rd_word = '0;
        endcase
    end

    always_comb begin
        rd_valid_d = mmio_rd_valid;
        rd_tid_d   = mmio_rd_valid ? mmio_tid : rd_tid_q;
        rd_data_d  = rd_data_q;
        if (mmio_rd_valid) begin
            if (len64) rd_data_d = rd_word;
            else if (mmio_addr[0]) rd_data_d = {32'b0, rd_word[63:32]};
            else rd_data_d = {32'b0, rd_word[31:0]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dsm_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            num_q      <= '0;
            ctl_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_tid_q   <= '0;
            rd_data_q  <= '0;
        end else begin
            dsm_q      <= dsm_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            num_q      <= num_d;
            ctl_q      <= ctl_d;
            rd_valid_q <= rd_valid_d;
            rd_tid_q   <= rd_tid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    hc_ctl_fsm u_fsm (
        .clk        (clk),
        .reset      (reset),
        .ctl_we     (ctl_we),
        .ctl_val    (mmio_wr_data[31:0]),
        .done_i     (done_i),
        .state      (state),
        .start_pulse(start_pulse),
        .stop_pulse (stop_pulse),
        .cycle_cnt  (cycle_cnt)
    );

    assign afu_rst      = (state == ST_IN_RESET);
    assign running      = (state == ST_RUN);
    assign rd_rsp_valid = rd_valid_q;
    assign rd_rsp_tid   = rd_tid_q;
    assign rd_rsp_data  = rd_data_q;
    assign dsm_base     = dsm_q;
    assign src_addr     = src_q;
    assign dst_addr     = dst_q;
    assign num_lines    = num_q;

endmodule

// File: tb/tb_hc_csr_bank.sv
// Directed bench for hc_csr_bank: reads, writes, run control,
// async reset and user status words against hand-computed values.
module tb_hc_csr_bank;

    localparam int N = 4;
    localparam logic [127:0] AID = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           mmio_rd_valid = 1'b0;
    logic           mmio_wr_valid = 1'b0;
    logic [15:0]    mmio_addr = '0;
    logic [1:0]     mmio_len = '0;
    logic [8:0]     mmio_tid = '0;
    logic [63:0]    mmio_wr_data = '0;
    logic           rd_rsp_valid;
    logic [8:0]     rd_rsp_tid;
    logic [63:0]    rd_rsp_data;
    logic [63:0]    dsm_base, src_addr, dst_addr;
    logic [31:0]    num_lines;
    logic           afu_rst, start_pulse, stop_pulse, running;
    logic           done_i = 1'b0;
    logic [64*N-1:0] status_i = '0;

    int checks = 0;
    int failures = 0;

    hc_csr_bank #(
        .AFU_ID       (AID),
        .DFH_NEXT     (24'h0),
        .DFH_EOL      (1'b1),
        .NUM_USER_CSRS(N),
        .USER_BASE    (16'h180)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mmio_rd_valid(mmio_rd_valid),
        .mmio_wr_valid(mmio_wr_valid),
        .mmio_addr    (mmio_addr),
        .mmio_len     (mmio_len),
        .mmio_tid     (mmio_tid),
        .mmio_wr_data (mmio_wr_data),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_tid   (rd_rsp_tid),
        .rd_rsp_data  (rd_rsp_data),
        .dsm_base     (dsm_base),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .num_lines    (num_lines),
        .afu_rst      (afu_rst),
        .start_pulse  (start_pulse),
        .stop_pulse   (stop_pulse),
        .running      (running),
        .done_i       (done_i),
        .status_i     (status_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [1:0] len, input logic [63:0] d);
        mmio_wr_valid = 1'b1;
        mmio_addr     = a;
        mmio_len      = len;
        mmio_wr_data  = d;
        tick();
        mmio_wr_valid = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [1:0] len,
                      input logic [8:0] tid, input logic [63:0] exp);
        mmio_rd_valid = 1'b1;
        mmio_addr     = a;
        mmio_len      = len;
        mmio_tid      = tid;
        tick();
        mmio_rd_valid = 1'b0;
        chk({tag, ".valid"}, {63'b0, rd_rsp_valid}, 64'd1);
        chk({tag, ".tid"}, {55'b0, rd_rsp_tid}, {55'b0, tid});
        chk({tag, ".data"}, rd_rsp_data, exp);
    endtask

    initial begin
        status_i[63:0]    = 64'h1111;
        status_i[255:192] = 64'hABCD;
        #1;
        chk("rst.afu_rst", {63'b0, afu_rst}, 64'd1);
        chk("rst.running", {63'b0, running}, 64'd0);
        chk("rst.rsp_valid", {63'b0, rd_rsp_valid}, 64'd0);
        chk("rst.pulses", {62'b0, start_pulse, stop_pulse}, 64'd0);
        chk("rst.src", src_addr, 64'd0);
        chk("rst.num", {32'b0, num_lines}, 64'd0);
        repeat (2) tick();
        reset = 1'b0;
        tick();

        rd("dfh", 16'h0000, 2'd1, 9'd5, 64'h1000_0100_0000_0000);
        rd("afu_lo", 16'h0002, 2'd1, 9'd6, 64'hFEDC_BA98_7654_3210);
        rd("afu_hi", 16'h0004, 2'd1, 9'd7, 64'h0123_4567_89AB_CDEF);
        tick();
        chk("rsp_once", {63'b0, rd_rsp_valid}, 64'd0);
        rd("dfh_hi32", 16'h0001, 2'd0, 9'd8, 64'h1000_0100);

        wr(16'h0048, 2'd1, 64'hDEAD_BEEF_0000_1000);
        chk("src64", src_addr, 64'hDEAD_BEEF_0000_1000);
        wr(16'h004A, 2'd0, 64'hFFFF_FFFF_0000_1234);
        chk("dst32", dst_addr, 64'h1234);
        rd("dst_rd", 16'h004A, 2'd1, 9'd9, 64'h1234);
        rd("src_odd32", 16'h0049, 2'd0, 9'd10, 64'hDEAD_BEEF);
        wr(16'h0049, 2'd0, 64'hCAFE);
        chk("src_hi32", src_addr, 64'h0000_CAFE_0000_1000);

        mmio_wr_valid = 1'b1;
        mmio_wr_data  = 64'h55;
        rd("rw_same", 16'h004C, 2'd1, 9'd11, 64'd0);
        mmio_wr_valid = 1'b0;
        chk("rw_same.num", {32'b0, num_lines}, 64'h55);
        rd("st_inrst", 16'h0052, 2'd1, 9'd12, 64'd0);

        wr(16'h004E, 2'd0, 64'd1);
        rd("st_idle", 16'h0052, 2'd1, 9'd13, 64'd1);
        wr(16'h004E, 2'd0, 64'd3);
        chk("start.pulse", {63'b0, start_pulse}, 64'd1);
        chk("start.running", {63'b0, running}, 64'd1);
        chk("start.afu_rst", {63'b0, afu_rst}, 64'd0);
        tick();
        chk("start.once", {63'b0, start_pulse}, 64'd0);
        repeat (8) tick();
        wr(16'h004E, 2'd0, 64'd7);
        chk("stop.pulse", {63'b0, stop_pulse}, 64'd1);
        chk("stop.running", {63'b0, running}, 64'd0);
        rd("st_done", 16'h0052, 2'd1, 9'd14, 64'd3);
        chk("stop.once", {63'b0, stop_pulse}, 64'd0);
        rd("cnt", 16'h0050, 2'd1, 9'd15, 64'd10);
        rd("ctl_rb", 16'h004E, 2'd1, 9'd16, 64'd7);

        wr(16'h004E, 2'd0, 64'd1);
        wr(16'h004E, 2'd0, 64'd3);
        rd("cnt_clr", 16'h0050, 2'd1, 9'd17, 64'd0);
        wr(16'h004C, 2'd1, 64'd8);
        chk("run.num_locked", {32'b0, num_lines}, 64'h55);
        wr(16'h0044, 2'd1, 64'h77);
        chk("run.dsm_locked", dsm_base, 64'd0);
        done_i = 1'b1;
        wr(16'h004E, 2'd0, 64'd7);
        done_i = 1'b0;
        chk("done.running", {63'b0, running}, 64'd0);
        chk("done.no_stop", {63'b0, stop_pulse}, 64'd0);
        rd("done.st", 16'h0052, 2'd1, 9'd18, 64'd3);

        wr(16'h004E, 2'd0, 64'd1);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        rd("idle_done_ign", 16'h0052, 2'd1, 9'd19, 64'd1);

        wr(16'h004E, 2'd0, 64'd3);
        chk("run2.running", {63'b0, running}, 64'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("arst.running", {63'b0, running}, 64'd0);
        chk("arst.afu_rst", {63'b0, afu_rst}, 64'd1);
        tick();
        reset = 1'b0;
        rd("arst.src", 16'h0048, 2'd1, 9'd20, 64'd0);
        rd("arst.num", 16'h004C, 2'd1, 9'd21, 64'd0);
        rd("arst.ctl", 16'h004E, 2'd1, 9'd22, 64'd0);
        rd("arst.cnt", 16'h0050, 2'd1, 9'd23, 64'd0);
        rd("arst.st", 16'h0052, 2'd1, 9'd24, 64'd0);

        rd("user0", 16'h0060, 2'd1, 9'd25, 64'h1111);
        rd("user3", 16'h0066, 2'd1, 9'd26, 64'hABCD);
        rd("user4", 16'h0068, 2'd1, 9'd27, 64'd0);
        rd("unmapped", 16'h0046, 2'd1, 9'd28, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
